// File: rtl/mm2s_key_loader_pkg.sv
// ----------------------------------------------------------------------------
// mm2s_key_loader_pkg
//   Shared definitions for the MM2S key loader:
//     state_t        : loader FSM state encoding (IDLE / KEY / DRAIN / ARMED)
//     KEY_WIDTH      : width of the assembled AES key (256)
//     KEY_WORD_WIDTH : width of one control-stream key word (32)
//     MAX_KEY_WORDS  : number of key words that fit in the key (8)
//     FLAG_NIBBLE    : default value required in flag word bits [31:28]
// ----------------------------------------------------------------------------
package mm2s_key_loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_KEY   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_ARMED = 2'd3
   } state_t;

   localparam int         KEY_WIDTH      = 256;
   localparam int         KEY_WORD_WIDTH = 32;
   localparam int         MAX_KEY_WORDS  = KEY_WIDTH / KEY_WORD_WIDTH;
   localparam logic [3:0] FLAG_NIBBLE    = 4'hA;

endpackage

// File: rtl/mm2s_key_loader.sv
// ----------------------------------------------------------------------------
// mm2s_key_loader
//   Parses the DMA MM2S control stream (flag word followed by key words) into a
//   256-bit AES key and gates the MM2S data stream so a packet's payload only
//   reaches the AES stage once that packet's key is loaded. The key is held
//   until the data tlast handshake of the packet.
//
// Ports
//   m_axi_mm2s_aclk          : clock
//   mm2s_prmry_reset_out_n   : asynchronous active-low reset
//   m_axis_mm2s_cntrl_*      : control stream in (tdata/tkeep/tvalid/tlast, tready out)
//   m_axis_mm2s_*            : data stream in (tdata/tkeep/tvalid/tlast, tready out)
//   aes_*                    : data stream out to AES stage (tready in)
//   aes_key / aes_key_valid  : assembled key and "key loaded, gate open"
//   key_err                  : one-cycle pulse after a control packet with a bad flag
//   key_dbg                  : {pkt_cnt, err_cnt} when MM2S_KEY_LOADER_DBG_EN is
//                              defined, otherwise tied to zero
//
// Build option
//   MM2S_KEY_LOADER_DBG_EN : enables the packet/error debug counters on key_dbg.
// ----------------------------------------------------------------------------
module mm2s_key_loader
   import mm2s_key_loader_pkg::*;
#(
   parameter int         C_M_AXIS_MM2S_TDATA_WIDTH       = 128,
   parameter int         C_M_AXIS_MM2S_CNTRL_TDATA_WIDTH = 32,
   parameter int         C_KEY_WORDS                     = 8,
   parameter logic [3:0] C_FLAG_NIBBLE                   = FLAG_NIBBLE
)(
   input  logic                                         m_axi_mm2s_aclk,
   input  logic                                         mm2s_prmry_reset_out_n,
   input  logic [C_M_AXIS_MM2S_CNTRL_TDATA_WIDTH-1:0]   m_axis_mm2s_cntrl_tdata,
   input  logic [C_M_AXIS_MM2S_CNTRL_TDATA_WIDTH/8-1:0] m_axis_mm2s_cntrl_tkeep,
   input  logic                                         m_axis_mm2s_cntrl_tvalid,
   input  logic                                         m_axis_mm2s_cntrl_tlast,
   output logic                                         m_axis_mm2s_cntrl_tready,
   input  logic [C_M_AXIS_MM2S_TDATA_WIDTH-1:0]         m_axis_mm2s_tdata,
   input  logic [C_M_AXIS_MM2S_TDATA_WIDTH/8-1:0]       m_axis_mm2s_tkeep,
   input  logic                                         m_axis_mm2s_tvalid,
   input  logic                                         m_axis_mm2s_tlast,
   output logic                                         m_axis_mm2s_tready,
   output logic [C_M_AXIS_MM2S_TDATA_WIDTH-1:0]         aes_tdata,
   output logic [C_M_AXIS_MM2S_TDATA_WIDTH/8-1:0]       aes_tkeep,
   output logic                                         aes_tvalid,
   output logic                                         aes_tlast,
   input  logic                                         aes_tready,
   output logic [KEY_WIDTH-1:0]                         aes_key,
   output logic                                         aes_key_valid,
   output logic                                         key_err,
   output logic [31:0]                                  key_dbg
);

   state_t     state_reg, state_next;
   logic [3:0] cnt_reg;
   logic [3:0] cnt_next;
   logic       flag_ok_reg;
   logic       key_err_reg;

   logic       armed;
   logic       ctl_hs;
   logic       dat_hs;
   logic       flag_ok;
   logic       key_clr;
   logic       unused_cntrl_tkeep;

   // Control tkeep carries no information for this block.
   assign unused_cntrl_tkeep = ^m_axis_mm2s_cntrl_tkeep;

   // The next packet's control is back-pressured while a key is in use.
   assign armed                    = (state_reg == ST_ARMED);
   assign m_axis_mm2s_cntrl_tready = ~armed;
   assign ctl_hs                   = m_axis_mm2s_cntrl_tvalid & ~armed;
   assign flag_ok = (m_axis_mm2s_cntrl_tdata[C_M_AXIS_MM2S_CNTRL_TDATA_WIDTH-1 -: 4] == C_FLAG_NIBBLE);

   // Data gate: zero-latency pass-through while armed, stalled otherwise.
   assign aes_tdata          = m_axis_mm2s_tdata;
   assign aes_tkeep          = m_axis_mm2s_tkeep;
   assign aes_tvalid         = armed & m_axis_mm2s_tvalid;
   assign aes_tlast          = armed & m_axis_mm2s_tlast;
   assign m_axis_mm2s_tready = armed & aes_tready;
   assign dat_hs             = m_axis_mm2s_tvalid & m_axis_mm2s_tready;

   assign aes_key_valid = armed;
   assign key_err       = key_err_reg;

   // A good flag word starts a fresh key, even when the packet carries no key words.
   assign key_clr  = (state_reg == ST_IDLE) & ctl_hs & flag_ok;
   // Word counter saturates so an over-long packet can never wrap onto word 0.
   assign cnt_next = (cnt_reg < 4'(C_KEY_WORDS)) ? cnt_reg + 4'd1 : cnt_reg;

   always_ff @(posedge m_axi_mm2s_aclk or negedge mm2s_prmry_reset_out_n) begin
      if (!mm2s_prmry_reset_out_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (ctl_hs) begin
               if (flag_ok) begin
                  state_next = m_axis_mm2s_cntrl_tlast ? ST_ARMED : ST_KEY;
               end else begin
                  state_next = m_axis_mm2s_cntrl_tlast ? ST_IDLE : ST_DRAIN;
               end
            end
         end
         ST_KEY: begin
            if (ctl_hs) begin
               if (m_axis_mm2s_cntrl_tlast) begin
                  state_next = ST_ARMED;
               end else if (cnt_next == 4'(C_KEY_WORDS)) begin
                  state_next = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (ctl_hs && m_axis_mm2s_cntrl_tlast) begin
               state_next = flag_ok_reg ? ST_ARMED : ST_IDLE;
            end
         end
         ST_ARMED: begin
            if (dat_hs && m_axis_mm2s_tlast) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // flag_ok_reg remembers whether a packet being drained should still arm.
   always_ff @(posedge m_axi_mm2s_aclk or negedge mm2s_prmry_reset_out_n) begin
      if (!mm2s_prmry_reset_out_n) begin
         cnt_reg     <= 4'd0;
         flag_ok_reg <= 1'b0;
         key_err_reg <= 1'b0;
      end else begin
         key_err_reg <= 1'b0;
         if (state_reg == ST_IDLE && ctl_hs) begin
            cnt_reg     <= 4'd0;
            flag_ok_reg <= flag_ok;
            key_err_reg <= ~flag_ok;
         end else if (state_reg == ST_KEY && ctl_hs) begin
            cnt_reg <= cnt_next;
         end
      end
   end

   // One register per key word; word 0 is the most significant 32 bits.
   genvar gi;
   generate
      for (gi = 0; gi < MAX_KEY_WORDS; gi++) begin : g_key_word
         logic [KEY_WORD_WIDTH-1:0] word_reg;
         logic                      word_we;

         assign word_we = (gi < C_KEY_WORDS) && (state_reg == ST_KEY) && ctl_hs &&
                          (cnt_reg == 4'(gi));

         always_ff @(posedge m_axi_mm2s_aclk or negedge mm2s_prmry_reset_out_n) begin
            if (!mm2s_prmry_reset_out_n) begin
               word_reg <= '0;
            end else if (key_clr) begin
               word_reg <= '0;
            end else if (word_we) begin
               word_reg <= m_axis_mm2s_cntrl_tdata;
            end
         end

         assign aes_key[KEY_WIDTH-1-KEY_WORD_WIDTH*gi -: KEY_WORD_WIDTH] = word_reg;
      end
   endgenerate

`ifdef MM2S_KEY_LOADER_DBG_EN
   logic [15:0] pkt_cnt_reg;
   logic [15:0] err_cnt_reg;

   always_ff @(posedge m_axi_mm2s_aclk or negedge mm2s_prmry_reset_out_n) begin
      if (!mm2s_prmry_reset_out_n) begin
         pkt_cnt_reg <= 16'd0;
         err_cnt_reg <= 16'd0;
      end else begin
         if (armed && dat_hs && m_axis_mm2s_tlast) begin
            pkt_cnt_reg <= pkt_cnt_reg + 16'd1;
         end
         if (key_err_reg) begin
            err_cnt_reg <= err_cnt_reg + 16'd1;
         end
      end
   end

   assign key_dbg = {pkt_cnt_reg, err_cnt_reg};
`else
   assign key_dbg = 32'h0;
`endif

endmodule

// File: tb/tb_mm2s_key_loader.sv
// ----------------------------------------------------------------------------
// tb_mm2s_key_loader
//   Directed plus randomized stimulus for mm2s_key_loader. Expected keys come
//   from a packet-level model: the key is the first eight key words of a
//   well-flagged control packet, left-justified and zero filled. Data beats
//   must leave the gate in order and unmodified. Honours MM2S_KEY_LOADER_DBG_EN.
// ----------------------------------------------------------------------------
module tb_mm2s_key_loader;

   typedef logic [144:0] beat_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [31:0]  c_tdata = '0;
   logic [3:0]   c_tkeep = '0;
   logic         c_tvalid = 1'b0;
   logic         c_tlast = 1'b0;
   logic         c_tready;
   logic [127:0] d_tdata = '0;
   logic [15:0]  d_tkeep = '0;
   logic         d_tvalid = 1'b0;
   logic         d_tlast = 1'b0;
   logic         d_tready;
   logic [127:0] a_tdata;
   logic [15:0]  a_tkeep;
   logic         a_tvalid;
   logic         a_tlast;
   logic         a_tready = 1'b1;
   logic [255:0] aes_key;
   logic         key_valid;
   logic         key_err;
   logic [31:0]  key_dbg;

   int checks = 0;
   int errors = 0;
   int viol = 0;
   int err_pulses = 0;
   int rdy_mode = 0;
   int exp_pkt = 0;
   int exp_err = 0;

   logic [31:0]  ctl_w [0:15];
   beat_t        exp_q [$];
   beat_t        obs_q [$];
   logic         prev_valid = 1'b0;
   logic [255:0] prev_key = '0;

   mm2s_key_loader dut (
      .m_axi_mm2s_aclk          (clk),
      .mm2s_prmry_reset_out_n   (rst_n),
      .m_axis_mm2s_cntrl_tdata  (c_tdata),
      .m_axis_mm2s_cntrl_tkeep  (c_tkeep),
      .m_axis_mm2s_cntrl_tvalid (c_tvalid),
      .m_axis_mm2s_cntrl_tlast  (c_tlast),
      .m_axis_mm2s_cntrl_tready (c_tready),
      .m_axis_mm2s_tdata        (d_tdata),
      .m_axis_mm2s_tkeep        (d_tkeep),
      .m_axis_mm2s_tvalid       (d_tvalid),
      .m_axis_mm2s_tlast        (d_tlast),
      .m_axis_mm2s_tready       (d_tready),
      .aes_tdata                (a_tdata),
      .aes_tkeep                (a_tkeep),
      .aes_tvalid               (a_tvalid),
      .aes_tlast                (a_tlast),
      .aes_tready               (a_tready),
      .aes_key                  (aes_key),
      .aes_key_valid            (key_valid),
      .key_err                  (key_err),
      .key_dbg                  (key_dbg)
   );

   always #5 clk = ~clk;

   // AES-side ready: 0 = always ready, 1 = toggling 1010, 2 = random.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       a_tready = 1'b1;
            1:       a_tready = ~a_tready;
            default: a_tready = 1'($urandom_range(1));
         endcase
      end
   end

   // Protocol monitor: captured beats, rule violations and key_err pulses.
   always @(negedge clk) begin
      if (rst_n) begin
         if (a_tvalid && a_tready) obs_q.push_back({a_tdata, a_tkeep, a_tlast});
         viol <= viol + int'(!a_tready && d_tready)
                      + int'(c_tvalid && c_tready && key_valid)
                      + int'(a_tvalid && !key_valid)
                      + int'(key_valid && prev_valid && (aes_key != prev_key));
         err_pulses <= err_pulses + int'(key_err);
         prev_valid <= key_valid;
         prev_key   <= aes_key;
      end else begin
         prev_valid <= 1'b0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Model key: first up to 8 key words, first word most significant, zero filled.
   function automatic logic [255:0] model_key(input int nkey);
      logic [255:0] k;
      k = '0;
      for (int j = 0; j < 8; j++) begin
         k = {k[223:0], (j < nkey) ? ctl_w[j + 1] : 32'h0};
      end
      return k;
   endfunction

   function automatic logic [31:0] exp_dbg();
`ifdef MM2S_KEY_LOADER_DBG_EN
      logic [15:0] p;
      logic [15:0] e;
      p = 16'(exp_pkt);
      e = 16'(exp_err);
      return {p, e};
`else
      return 32'h0;
`endif
   endfunction

   task automatic fill_random(input bit bad, input int nkey);
      int nib;
      nib = bad ? $urandom_range(15) : 10;
      if (bad && nib == 10) nib = 5;
      ctl_w[0] = {4'(nib), 28'($urandom)};
      for (int i = 1; i <= nkey && i < 16; i++) ctl_w[i] = $urandom;
   endtask

   task automatic send_ctl(input int n, input bit with_tlast, input int limit);
      for (int i = 0; i < n; i++) begin
         int waited;
         waited = 0;
         if ($urandom_range(3) == 0) begin
            c_tvalid = 1'b0;
            @(posedge clk);
            #1;
         end
         c_tdata  = ctl_w[i];
         c_tkeep  = 4'($urandom);
         c_tlast  = with_tlast && (i == n - 1);
         c_tvalid = 1'b1;
         @(negedge clk);
         while (!c_tready && waited < limit) begin
            waited++;
            @(negedge clk);
         end
         check("ctl_timeout", 256'(waited >= limit), 256'(0));
         @(posedge clk);
         #1;
      end
      c_tvalid = 1'b0;
      c_tlast  = 1'b0;
   endtask

   task automatic send_data(input int n, input int limit);
      for (int b = 0; b < n; b++) begin
         int waited;
         waited = 0;
         if ($urandom_range(3) == 0) begin
            d_tvalid = 1'b0;
            @(posedge clk);
            #1;
         end
         d_tdata  = {$urandom, $urandom, $urandom, $urandom};
         d_tkeep  = 16'($urandom);
         d_tlast  = (b == n - 1);
         d_tvalid = 1'b1;
         @(negedge clk);
         while (!d_tready && waited < limit) begin
            waited++;
            @(negedge clk);
         end
         check("data_timeout", 256'(waited >= limit), 256'(0));
         exp_q.push_back({d_tdata, d_tkeep, d_tlast});
         @(posedge clk);
         #1;
      end
      d_tvalid = 1'b0;
      d_tlast  = 1'b0;
   endtask

   task automatic check_data(input string tag);
      int n;
      check({tag, " beat_count"}, 256'(obs_q.size()), 256'(exp_q.size()));
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check({tag, " beat"}, 256'(obs_q[i]), 256'(exp_q[i]));
      obs_q.delete();
      exp_q.delete();
   endtask

   // One complete packet from ctl_w[0..nkey], checked against the model.
   task automatic run_packet(input string tag, input int nkey, input int nbeats);
      logic [255:0] exp_key;
      bit           bad;
      int           e0;
      e0      = err_pulses;
      bad     = (ctl_w[0][31:28] != 4'hA);
      exp_key = model_key(nkey);
      send_ctl(nkey + 1, 1'b1, 300);
      if (bad) begin
         @(negedge clk);
         #1;
         check({tag, " key_valid"}, 256'(key_valid), 256'(0));
         check({tag, " cntrl_tready"}, 256'(c_tready), 256'(1));
         d_tdata  = {$urandom, $urandom, $urandom, $urandom};
         d_tvalid = 1'b1;
         repeat (3) begin
            @(negedge clk);
            check({tag, " held_tready"}, 256'(d_tready), 256'(0));
            check({tag, " held_aes_tvalid"}, 256'(a_tvalid), 256'(0));
         end
         @(posedge clk);
         #1;
         d_tvalid = 1'b0;
         exp_err++;
      end else begin
         check({tag, " key_valid"}, 256'(key_valid), 256'(1));
         check({tag, " key"}, aes_key, exp_key);
         check({tag, " cntrl_tready"}, 256'(c_tready), 256'(0));
         send_data(nbeats, 300);
         check_data(tag);
         check({tag, " idle_valid"}, 256'(key_valid), 256'(0));
         check({tag, " idle_tready"}, 256'(c_tready), 256'(1));
         check({tag, " key_retained"}, aes_key, exp_key);
         exp_pkt++;
      end
      check({tag, " key_err_pulses"}, 256'(err_pulses - e0), 256'(bad ? 1 : 0));
      check({tag, " key_dbg"}, 256'(key_dbg), 256'(exp_dbg()));
      check({tag, " violations"}, 256'(viol), 256'(0));
      $display("packet %s nkey=%0d bad=%0d beats=%0d key=%h", tag, nkey, bad, nbeats, exp_key);
   endtask

   task automatic load_test1_words();
      ctl_w[0] = 32'hA000_0000;
      for (int i = 0; i < 8; i++) begin
         logic [7:0] b;
         b = 8'(4 * i);
         ctl_w[i + 1] = {b, b + 8'd1, b + 8'd2, b + 8'd3};
      end
   endtask

   initial begin
      logic [255:0] exp_a;
      logic [255:0] exp_b;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst key", aes_key, 256'(0));
      check("rst key_valid", 256'(key_valid), 256'(0));
      check("rst key_err", 256'(key_err), 256'(0));
      check("rst key_dbg", 256'(key_dbg), 256'(0));
      check("rst cntrl_tready", 256'(c_tready), 256'(1));
      check("rst aes_tvalid", 256'(a_tvalid), 256'(0));
      check("rst mm2s_tready", 256'(d_tready), 256'(0));
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: full 8-word key, 4 beats
      load_test1_words();
      run_packet("t1", 8, 4);
      check("t1 literal key", aes_key,
            256'h00010203_04050607_08090a0b_0c0d0e0f_10111213_14151617_18191a1b_1c1d1e1f);

      // 2: short key, zero filled
      ctl_w[0] = 32'hA000_0000;
      ctl_w[1] = 32'h1111_1111;
      ctl_w[2] = 32'h2222_2222;
      run_packet("t2", 2, 2);
      check("t2 literal key", aes_key, {64'h11111111_22222222, 192'h0});

      // 3: bad flag, words drained
      fill_random(1'b0, 3);
      ctl_w[0] = 32'h5000_0000;
      run_packet("t3", 3, 1);

      // 4: 10 key words, last two discarded
      fill_random(1'b0, 10);
      run_packet("t4", 10, 3);

      // 5: toggling ready, next packet's control arrives while armed
      rdy_mode = 1;
      fill_random(1'b0, 8);
      exp_a = model_key(8);
      send_ctl(9, 1'b1, 300);
      check("t5 key_a", aes_key, exp_a);
      check("t5 cntrl_tready", 256'(c_tready), 256'(0));
      fork
         send_data(4, 300);
         begin
            @(posedge clk);
            #1;
            fill_random(1'b0, 3);
            exp_b = model_key(3);
            send_ctl(4, 1'b1, 500);
         end
      join
      check_data("t5a");
      exp_pkt++;
      check("t5 key_b_valid", 256'(key_valid), 256'(1));
      check("t5 key_b", aes_key, exp_b);
      send_data(2, 300);
      check_data("t5b");
      exp_pkt++;
      check("t5 key_dbg", 256'(key_dbg), 256'(exp_dbg()));
      check("t5 violations", 256'(viol), 256'(0));
      $display("packet t5 key_a=%h key_b=%h", exp_a, exp_b);
      rdy_mode = 0;

      // Randomized packets: any flag, 0..11 key words, any ready pattern
      for (int it = 0; it < 14; it++) begin
         bit bad;
         int nkey;
         bad      = ($urandom_range(5) == 0);
         nkey     = $urandom_range(11);
         rdy_mode = $urandom_range(2);
         fill_random(bad, nkey);
         run_packet("rnd", nkey, $urandom_range(1, 5));
      end
      rdy_mode = 0;

      // 6: asynchronous reset mid-KEY, then a full packet
      fill_random(1'b0, 3);
      send_ctl(4, 1'b0, 300);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6 key", aes_key, 256'(0));
      check("t6 key_valid", 256'(key_valid), 256'(0));
      check("t6 cntrl_tready", 256'(c_tready), 256'(1));
      check("t6 mm2s_tready", 256'(d_tready), 256'(0));
      check("t6 key_dbg", 256'(key_dbg), 256'(0));
      exp_pkt = 0;
      exp_err = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      load_test1_words();
      run_packet("t6", 8, 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
